// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         DEFAULT_MUL_LATENCY = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline-side hazard inputs and stage enable/flush controls.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       i_ifidRs;
    logic [4:0]       i_ifidRt;
    logic             i_ifidUsesRt;
    logic             i_idexMemRead;
    logic [4:0]       i_idexRt;
    logic             i_idexMultiCycle;
    logic             i_exBranchTaken;
    logic             o_pcWrite;
    logic             o_ifidWrite;
    logic             o_ifidFlush;
    logic             o_idexBubble;
    logic             o_exHold;
    logic             o_stall;
    logic [CNT_W-1:0] o_loadUseCount;
    logic [CNT_W-1:0] o_mulStallCount;

    modport master (
        output i_ifidRs, i_ifidRt, i_ifidUsesRt, i_idexMemRead,
               i_idexRt, i_idexMultiCycle, i_exBranchTaken,
        input  o_pcWrite, o_ifidWrite, o_ifidFlush, o_idexBubble,
               o_exHold, o_stall, o_loadUseCount, o_mulStallCount
    );

    modport slave (
        input  i_ifidRs, i_ifidRt, i_ifidUsesRt, i_idexMemRead,
               i_idexRt, i_idexMultiCycle, i_exBranchTaken,
        output o_pcWrite, o_ifidWrite, o_ifidFlush, o_idexBubble,
               o_exHold, o_stall, o_loadUseCount, o_mulStallCount
    );

endinterface

// File: rtl/mul_stall_counter.sv
// Multi-cycle EX sequencer: RUN/MUL_WAIT state, remaining-cycle counter and
// the one-cycle release mask that stops a departing op from retriggering.
module mul_stall_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_start,
    output state_t o_state,
    output logic   o_zero,
    output logic   o_mask
);

    localparam int CNT_BITS = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] LOAD_VAL =
        CNT_BITS'((MUL_LATENCY > 2) ? (MUL_LATENCY - 2) : 0);

    state_t              r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_mask;

    // Latency 2 never leaves RUN; it only needs the mask for the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_mask  <= 1'b0;
        end else begin
            r_mask <= 1'b0;
            case (r_state)
                RUN: begin
                    if (i_start) begin
                        if (MUL_LATENCY > 2) begin
                            r_cnt   <= LOAD_VAL;
                            r_state <= MUL_WAIT;
                        end else begin
                            r_mask <= 1'b1;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_BITS'(1);
                    end else begin
                        r_state <= RUN;
                        r_mask  <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_zero  = (r_cnt == '0);
    assign o_mask  = r_mask;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline (load-use, branch flush, mul hold).
// Optional saturating perf counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic MC_EN = (MUL_LATENCY > 1);

    state_t w_state;
    logic   w_zero;
    logic   w_mask;
    logic   w_loadUse;
    logic   w_mcEff;
    logic   w_mcStart;
    logic   w_luBubble;
    logic   w_pcWrite;
    logic   w_ifidWrite;
    logic   w_ifidFlush;
    logic   w_idexBubble;
    logic   w_exHold;

    assign w_loadUse = hz.i_idexMemRead && (hz.i_idexRt != REG_ZERO) &&
                       ((hz.i_idexRt == hz.i_ifidRs) ||
                        (hz.i_ifidUsesRt && (hz.i_idexRt == hz.i_ifidRt)));
    assign w_mcEff   = hz.i_idexMultiCycle && !w_mask && MC_EN;

    mul_stall_counter #(
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mulCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mcStart),
        .o_state (w_state),
        .o_zero  (w_zero),
        .o_mask  (w_mask)
    );

    // Reset forces a safe bubble; otherwise branch > mul > load-use in RUN.
    always_comb begin
        w_pcWrite    = 1'b1;
        w_ifidWrite  = 1'b1;
        w_ifidFlush  = 1'b0;
        w_idexBubble = 1'b0;
        w_exHold     = 1'b0;
        w_mcStart    = 1'b0;
        w_luBubble   = 1'b0;
        if (!rst_n) begin
            w_pcWrite    = 1'b0;
            w_ifidWrite  = 1'b0;
            w_ifidFlush  = 1'b1;
            w_idexBubble = 1'b1;
        end else if (w_state == MUL_WAIT) begin
            if (!w_zero) begin
                w_pcWrite   = 1'b0;
                w_ifidWrite = 1'b0;
                w_exHold    = 1'b1;
            end
        end else if (hz.i_exBranchTaken) begin
            w_ifidFlush  = 1'b1;
            w_idexBubble = 1'b1;
        end else if (w_mcEff) begin
            w_pcWrite   = 1'b0;
            w_ifidWrite = 1'b0;
            w_exHold    = 1'b1;
            w_mcStart   = 1'b1;
        end else if (w_loadUse) begin
            w_pcWrite    = 1'b0;
            w_ifidWrite  = 1'b0;
            w_idexBubble = 1'b1;
            w_luBubble   = 1'b1;
        end
    end

    assign hz.o_pcWrite    = w_pcWrite;
    assign hz.o_ifidWrite  = w_ifidWrite;
    assign hz.o_ifidFlush  = w_ifidFlush;
    assign hz.o_idexBubble = w_idexBubble;
    assign hz.o_exHold     = w_exHold;
    assign hz.o_stall      = !w_pcWrite;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_luCnt;
    logic [CNT_W-1:0] r_msCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_luCnt <= '0;
            r_msCnt <= '0;
        end else begin
            if (w_luBubble && (r_luCnt != '1)) r_luCnt <= r_luCnt + CNT_W'(1);
            if (w_exHold && (r_msCnt != '1))   r_msCnt <= r_msCnt + CNT_W'(1);
        end
    end

    assign hz.o_loadUseCount  = r_luCnt;
    assign hz.o_mulStallCount = r_msCnt;
`else
    assign hz.o_loadUseCount  = '0;
    assign hz.o_mulStallCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: three controllers (MUL_LATENCY 4, 2, 1) driven with identical stimulus.
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] P_NORM = 6'b110000;
    localparam logic [5:0] P_LU   = 6'b000101;
    localparam logic [5:0] P_BR   = 6'b111100;
    localparam logic [5:0] P_HOLD = 6'b000011;
    localparam logic [5:0] P_RST  = 6'b001101;
    localparam int         CW     = 4;
    localparam int         CMAX   = 15;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   tallyLu [3];
    int   tallyMs [3];

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) if4 ();
    pipeline_hazard_ctrl_if #(.CNT_W(CW)) if2 ();
    pipeline_hazard_ctrl_if #(.CNT_W(CW)) if1 ();

    pipeline_hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(CW)) dut4 (.clk(clk), .rst_n(rst_n), .hz(if4));
    pipeline_hazard_ctrl #(.MUL_LATENCY(2), .CNT_W(CW)) dut2 (.clk(clk), .rst_n(rst_n), .hz(if2));
    pipeline_hazard_ctrl #(.MUL_LATENCY(1), .CNT_W(CW)) dut1 (.clk(clk), .rst_n(rst_n), .hz(if1));

    logic [5:0]    act [3];
    logic [CW-1:0] luAct [3];
    logic [CW-1:0] msAct [3];

    assign act[0] = {if4.o_pcWrite, if4.o_ifidWrite, if4.o_ifidFlush, if4.o_idexBubble, if4.o_exHold, if4.o_stall};
    assign act[1] = {if2.o_pcWrite, if2.o_ifidWrite, if2.o_ifidFlush, if2.o_idexBubble, if2.o_exHold, if2.o_stall};
    assign act[2] = {if1.o_pcWrite, if1.o_ifidWrite, if1.o_ifidFlush, if1.o_idexBubble, if1.o_exHold, if1.o_stall};
    assign luAct[0] = if4.o_loadUseCount;
    assign luAct[1] = if2.o_loadUseCount;
    assign luAct[2] = if1.o_loadUseCount;
    assign msAct[0] = if4.o_mulStallCount;
    assign msAct[1] = if2.o_mulStallCount;
    assign msAct[2] = if1.o_mulStallCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       memRead;
        logic [4:0] idexRt;
        logic       mc;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic setInputs(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                             input logic memRead, input logic [4:0] idexRt,
                             input logic mc, input logic br);
        if4.i_ifidRs = rs; if4.i_ifidRt = rt; if4.i_ifidUsesRt = usesRt;
        if4.i_idexMemRead = memRead; if4.i_idexRt = idexRt;
        if4.i_idexMultiCycle = mc; if4.i_exBranchTaken = br;
        if2.i_ifidRs = rs; if2.i_ifidRt = rt; if2.i_ifidUsesRt = usesRt;
        if2.i_idexMemRead = memRead; if2.i_idexRt = idexRt;
        if2.i_idexMultiCycle = mc; if2.i_exBranchTaken = br;
        if1.i_ifidRs = rs; if1.i_ifidRt = rt; if1.i_ifidUsesRt = usesRt;
        if1.i_idexMemRead = memRead; if1.i_idexRt = idexRt;
        if1.i_idexMultiCycle = mc; if1.i_exBranchTaken = br;
    endtask

    task automatic checkCounters(input string name);
        for (int d = 0; d < 3; d++) begin
`ifdef HAZARD_PERF_EN
            total++;
            if (luAct[d] !== CW'(tallyLu[d])) begin
                bad++;
                $display("[TB] FAIL %s loadUseCount dut%0d: got %0d expected %0d", name, d, luAct[d], tallyLu[d]);
            end
            total++;
            if (msAct[d] !== CW'(tallyMs[d])) begin
                bad++;
                $display("[TB] FAIL %s mulStallCount dut%0d: got %0d expected %0d", name, d, msAct[d], tallyMs[d]);
            end
`else
            total++;
            if ((luAct[d] !== '0) || (msAct[d] !== '0)) begin
                bad++;
                $display("[TB] FAIL %s counters dut%0d: got %0d/%0d expected 0/0", name, d, luAct[d], msAct[d]);
            end
`endif
        end
    endtask

    task automatic checkOutput(input string name, input logic [5:0] e4, input logic [5:0] e2, input logic [5:0] e1);
        logic [5:0] exp [3];
        exp[0] = e4; exp[1] = e2; exp[2] = e1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (act[d] !== exp[d]) begin
                bad++;
                $display("[TB] FAIL %s dut%0d {pc,ifid,flush,bubble,hold,stall}: got %b expected %b", name, d, act[d], exp[d]);
            end
            if ((exp[d] == P_LU) && (tallyLu[d] < CMAX)) tallyLu[d]++;
            if (exp[d][1] && (tallyMs[d] < CMAX)) tallyMs[d]++;
        end
    endtask

    task automatic applyStimulus(input string name, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic usesRt, input logic memRead, input logic [4:0] idexRt,
                                 input logic mc, input logic br);
        @(posedge clk);
        #1 checkCounters(name);
        #1 setInputs(rs, rt, usesRt, memRead, idexRt, mc, br);
        #3;
    endtask

    task automatic clearTallies();
        for (int d = 0; d < 3; d++) begin
            tallyLu[d] = 0;
            tallyMs[d] = 0;
        end
    endtask

    logic [5:0] seq4 [7];
    logic [5:0] seq2 [7];
    logic [5:0] seq1 [7];

    initial begin
        total = 0;
        bad   = 0;
        clearTallies();

        vecs[0] = '{5'd8,  5'd9, 1'b1, 1'b0, 5'd8,  1'b0, 1'b0, P_NORM};
        vecs[1] = '{5'd8,  5'd9, 1'b1, 1'b1, 5'd8,  1'b0, 1'b0, P_LU};
        vecs[2] = '{5'd0,  5'd0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, P_NORM};
        vecs[3] = '{5'd3,  5'd8, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, P_NORM};
        vecs[4] = '{5'd3,  5'd8, 1'b1, 1'b1, 5'd8,  1'b0, 1'b0, P_LU};
        vecs[5] = '{5'd8,  5'd8, 1'b1, 1'b0, 5'd8,  1'b0, 1'b0, P_NORM};
        vecs[6] = '{5'd8,  5'd9, 1'b1, 1'b1, 5'd8,  1'b0, 1'b1, P_BR};
        vecs[7] = '{5'd8,  5'd9, 1'b1, 1'b1, 5'd8,  1'b1, 1'b1, P_BR};
        vecs[8] = '{5'd1,  5'd2, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, P_BR};
        vecs[9] = '{5'd31, 5'd2, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, P_LU};

        seq4 = '{P_HOLD, P_HOLD, P_HOLD, P_NORM, P_NORM, P_HOLD, P_HOLD};
        seq2 = '{P_HOLD, P_NORM, P_BR,   P_HOLD, P_NORM, P_HOLD, P_NORM};
        seq1 = '{P_NORM, P_NORM, P_BR,   P_NORM, P_NORM, P_NORM, P_NORM};

        rst_n = 1'b0;
        setInputs(5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1);
        #3 checkOutput("resetAsserted", P_RST, P_RST, P_RST);
        @(posedge clk);
        #2 checkOutput("resetHeld", P_RST, P_RST, P_RST);
        clearTallies();
        @(posedge clk);
        #2 rst_n = 1'b1;
        setInputs(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 checkOutput("resetRelease", P_NORM, P_NORM, P_NORM);

        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].rs, vecs[i].rt, vecs[i].usesRt,
                          vecs[i].memRead, vecs[i].idexRt, vecs[i].mc, vecs[i].br);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp, vecs[i].exp);
        end

        applyStimulus("luOnce", 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        checkOutput("luOnce", P_LU, P_LU, P_LU);
        applyStimulus("luCleared", 5'd8, 5'd9, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0);
        checkOutput("luCleared", P_NORM, P_NORM, P_NORM);

        for (int c = 0; c < 7; c++) begin
            if (c == 2)
                applyStimulus($sformatf("mul%0d", c), 5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1);
            else
                applyStimulus($sformatf("mul%0d", c), 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
            checkOutput($sformatf("mul%0d", c), seq4[c], seq2[c], seq1[c]);
        end

        applyStimulus("mulWait2", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        checkOutput("mulWait2", P_HOLD, P_HOLD, P_NORM);
        #1 rst_n = 1'b0;
        #1 checkOutput("resetMidStall", P_RST, P_RST, P_RST);
        clearTallies();
        @(posedge clk);
        #2 checkOutput("resetMidHeld", P_RST, P_RST, P_RST);
        #1 rst_n = 1'b1;
        setInputs(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 checkOutput("postResetRun", P_NORM, P_NORM, P_NORM);

        applyStimulus("freshMul0", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        checkOutput("freshMul0", P_HOLD, P_HOLD, P_NORM);
        for (int c = 1; c < 4; c++) begin
            applyStimulus($sformatf("freshMul%0d", c), 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
            checkOutput($sformatf("freshMul%0d", c), (c < 3) ? P_HOLD : P_NORM, P_NORM, P_NORM);
        end

        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("luSat%0d", i), 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
            checkOutput($sformatf("luSat%0d", i), P_LU, P_LU, P_LU);
        end
        applyStimulus("final", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("final", P_NORM, P_NORM, P_NORM);
        @(posedge clk);
        #1 checkCounters("finalCounters");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
